// File: rtl/fpa_pkg.sv
// Shared constants and stage records for the three-stage add/subtract pipe.
package fpa_pkg;

  localparam int MW_DEF = 4;
  localparam int EW_DEF = 2;
  localparam int GW_DEF = 4;
  localparam int RW_DEF = MW_DEF + GW_DEF;

  // Aligned operands; mantissas carry one spare top bit for the sum carry.
  typedef struct packed {
    logic                vld;
    logic                sa;
    logic                sb;
    logic [EW_DEF-1:0]   e;
    logic [RW_DEF:0]     ma;
    logic [RW_DEF:0]     mb;
  } align_t;

  // Signed-magnitude sum before normalisation.
  typedef struct packed {
    logic                vld;
    logic                s;
    logic [EW_DEF-1:0]   e;
    logic [RW_DEF:0]     m;
  } sum_t;

  // Normalised result as presented on the output ports.
  typedef struct packed {
    logic                vld;
    logic                s;
    logic [EW_DEF:0]     e;
    logic [RW_DEF-1:0]   m;
    logic                z;
  } norm_t;

endpackage

// File: rtl/fpa_lzc.sv
// Leading-zero counter; an all-zero input reports W.
module fpa_lzc #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_data,
  output logic [CW-1:0] o_cnt
);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    o_cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (i_data[i]) o_cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fpa_pipe.sv
// Three-stage sign-magnitude add/subtract: align, add, normalise.
// Stage records come from fpa_pkg, so parameter overrides must track it.
module fpa_pipe
  import fpa_pkg::*;
#(
  parameter int MW = MW_DEF,
  parameter int EW = EW_DEF,
  parameter int GW = GW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MW-1:0]    ca,
  input  logic [EW-1:0]    ea,
  input  logic             sa,
  input  logic [MW-1:0]    cb,
  input  logic [EW-1:0]    eb,
  input  logic             sb,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MW+GW-1:0] co,
  output logic [EW:0]      eo,
  output logic             so,
  output logic             zero
);

  localparam int RW = MW + GW;
  localparam int CW = $clog2(RW + 1);

  align_t r_s1, w_s1;
  sum_t   r_s2, w_s2;
  norm_t  r_s3, w_s3;

  logic          w_en;
  logic          w_a_base;
  logic [EW-1:0] w_diff;
  logic [RW:0]   w_xa, w_xb, w_small;
  logic [CW-1:0] w_lz, w_shamt;

  // The whole pipe stalls only when a finished result is not being taken.
  assign w_en     = !r_s3.vld || out_ready;
  assign in_ready = w_en;

  // S1: widen mantissas, pick the base operand, shift the other into place.
  always_comb begin
    w_xa     = {1'b0, ca, {GW{1'b0}}};
    w_xb     = {1'b0, cb, {GW{1'b0}}};
    w_a_base = (ea >= eb);
    w_diff   = w_a_base ? (ea - eb) : (eb - ea);
    w_small  = w_a_base ? w_xb : w_xa;
    if (32'(w_diff) >= RW) w_small = '0;
    else                   w_small = w_small >> w_diff;
    w_s1     = '0;
    w_s1.vld = in_valid;
    w_s1.sa  = sa;
    w_s1.sb  = sb ^ op_sub;
    w_s1.e   = w_a_base ? ea : eb;
    w_s1.ma  = w_a_base ? w_xa : w_small;
    w_s1.mb  = w_a_base ? w_small : w_xb;
  end

  // S2: add like signs, otherwise subtract the smaller magnitude from the larger.
  always_comb begin
    w_s2     = '0;
    w_s2.vld = r_s1.vld;
    w_s2.e   = r_s1.e;
    if (r_s1.sa == r_s1.sb) begin
      w_s2.m = r_s1.ma + r_s1.mb;
      w_s2.s = r_s1.sa;
    end else if (r_s1.ma >= r_s1.mb) begin
      w_s2.m = r_s1.ma - r_s1.mb;
      w_s2.s = r_s1.sa;
    end else begin
      w_s2.m = r_s1.mb - r_s1.ma;
      w_s2.s = r_s1.sb;
    end
  end

  fpa_lzc #(.W(RW), .CW(CW)) u_lzc (
    .i_data (r_s2.m[RW-1:0]),
    .o_cnt  (w_lz)
  );

  // S3: absorb a carry, or shift left as far as the exponent allows; zero is canonical.
  always_comb begin
    w_shamt  = (32'(w_lz) > 32'(r_s2.e)) ? CW'(r_s2.e) : w_lz;
    w_s3     = '0;
    w_s3.vld = r_s2.vld;
    if (r_s2.m[RW]) begin
      w_s3.m = r_s2.m[RW:1];
      w_s3.e = {1'b0, r_s2.e} + 1'b1;
      w_s3.s = r_s2.s;
    end else if (r_s2.m == '0) begin
      w_s3.z = 1'b1;
    end else begin
      w_s3.m = r_s2.m[RW-1:0] << w_shamt;
      w_s3.e = {1'b0, r_s2.e} - (EW+1)'(w_shamt);
      w_s3.s = r_s2.s;
    end
  end

  // Stage registers advance together; reset empties every stage at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else if (w_en) begin
      r_s1 <= w_s1;
      r_s2 <= w_s2;
      r_s3 <= w_s3;
    end
  end

  assign out_valid = r_s3.vld;
  assign co        = r_s3.m;
  assign eo        = r_s3.e;
  assign so        = r_s3.s;
  assign zero      = r_s3.z;

endmodule

// File: tb/tb_fpa_pipe.sv
// Bench for fpa_pipe: directed cases, stall/reset scenarios and random traffic
// checked against an integer-arithmetic reference model.
module tb_fpa_pipe;

  localparam int MW = 4;
  localparam int EW = 2;
  localparam int GW = 4;
  localparam int RW = MW + GW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] ca, cb;
  logic [EW-1:0] ea, eb;
  logic          sa, sb, op_sub;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] co;
  logic [EW:0]   eo;
  logic          so, zero;

  int            n_chk = 0;
  int            n_pass = 0;
  logic [12:0]   exp_q[$];
  bit            acc_in, acc_out;
  bit            prev_stall = 1'b0;
  logic [12:0]   prev_vec, obs_vec;

  logic [MW-1:0] p_ca[5], p_cb[5];
  logic [EW-1:0] p_ea[5], p_eb[5];
  logic          p_sa[5], p_sb[5], p_op[5];
  int            idx;

  fpa_pipe #(.MW(MW), .EW(EW), .GW(GW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ca        (ca),
    .ea        (ea),
    .sa        (sa),
    .cb        (cb),
    .eb        (eb),
    .sb        (sb),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .co        (co),
    .eo        (eo),
    .so        (so),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: signed integer arithmetic on scaled mantissas, then a
  // normalisation loop bounded by the exponent floor.
  function automatic logic [12:0] model(logic [3:0] a_c, logic [1:0] a_e, logic a_s,
                                        logic [3:0] b_c, logic [1:0] b_e, logic b_s, logic op);
    int ma, mb, e, d, r, mag;
    logic s;
    logic [7:0] m8;
    logic [2:0] e3;
    ma = int'(a_c) * (1 << GW);
    mb = int'(b_c) * (1 << GW);
    if (int'(a_e) >= int'(b_e)) begin
      e  = int'(a_e);
      d  = int'(a_e) - int'(b_e);
      mb = (d >= RW) ? 0 : mb / (1 << d);
    end else begin
      e  = int'(b_e);
      d  = int'(b_e) - int'(a_e);
      ma = (d >= RW) ? 0 : ma / (1 << d);
    end
    r   = (a_s ? -ma : ma) + ((b_s ^ op) ? -mb : mb);
    mag = (r < 0) ? -r : r;
    s   = (r < 0);
    if (mag == 0) return 13'b1;
    if (mag >= (1 << RW)) begin
      mag = mag / 2;
      e   = e + 1;
    end else begin
      while (mag < (1 << (RW - 1)) && e > 0) begin
        mag = mag * 2;
        e   = e - 1;
      end
    end
    m8 = mag[7:0];
    e3 = e[2:0];
    return {m8, e3, s, 1'b0};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(logic [3:0] a_c, logic [1:0] a_e, logic a_s,
                       logic [3:0] b_c, logic [1:0] b_e, logic b_s, logic op);
    ca = a_c; ea = a_e; sa = a_s;
    cb = b_c; eb = b_e; sb = b_s; op_sub = op;
  endtask

  task automatic drive_rand();
    drive(4'($urandom), 2'($urandom), 1'($urandom), 4'($urandom), 2'($urandom),
          1'($urandom), 1'($urandom));
  endtask

  // One clock: sample handshakes and outputs mid-cycle, score them, then step past the edge.
  task automatic tick();
    @(negedge clk);
    acc_in  = in_valid && in_ready;
    acc_out = out_valid && out_ready;
    obs_vec = {co, eo, so, zero};
    if (prev_stall) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", obs_vec, prev_vec);
    end
    prev_stall = out_valid && !out_ready;
    prev_vec   = obs_vec;
    if (acc_in) exp_q.push_back(model(ca, ea, sa, cb, eb, sb, op_sub));
    if (acc_out) begin
      if (exp_q.size() == 0) check("unexpected_out", out_valid, 0);
      else                   check("result", obs_vec, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic directed(string tag, logic [3:0] a_c, logic [1:0] a_e, logic a_s,
                          logic [3:0] b_c, logic [1:0] b_e, logic b_s, logic op,
                          logic [12:0] exp);
    drive(a_c, a_e, a_s, b_c, b_e, b_s, op);
    in_valid = 1'b1;
    tick();
    check({tag, "_accepted"}, 32'(acc_in), 1);
    in_valid = 1'b0;
    tick();
    check({tag, "_not_early"}, out_valid, 0);
    tick();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_value"}, {co, eo, so, zero}, exp);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_co", co, 0);
    check("rst_eo", eo, 0);
    check("rst_so", so, 0);
    check("rst_zero", zero, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);

    directed("add_equal",  4'b1000, 2'b01, 0, 4'b1000, 2'b01, 0, 0, {8'b10000000, 3'b010, 1'b0, 1'b0});
    directed("add_align",  4'b1000, 2'b01, 0, 4'b0100, 2'b00, 0, 0, {8'b10100000, 3'b001, 1'b0, 1'b0});
    directed("sub_cancel", 4'b1010, 2'b10, 0, 4'b1010, 2'b10, 0, 1, {8'b00000000, 3'b000, 1'b0, 1'b1});
    directed("mixed_sign", 4'b1000, 2'b11, 0, 4'b1100, 2'b11, 1, 0, {8'b10000000, 3'b010, 1'b1, 1'b0});

    // Backpressure: five pairs offered while the consumer is stalled.
    for (int i = 0; i < 5; i++) begin
      p_ca[i] = 4'($urandom); p_ea[i] = 2'($urandom); p_sa[i] = 1'($urandom);
      p_cb[i] = 4'($urandom); p_eb[i] = 2'($urandom); p_sb[i] = 1'($urandom);
      p_op[i] = 1'($urandom);
    end
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 5);
      if (idx < 5) drive(p_ca[idx], p_ea[idx], p_sa[idx], p_cb[idx], p_eb[idx], p_sb[idx], p_op[idx]);
      tick();
      if (acc_in) idx++;
    end
    check("stall_accepted", idx, 3);
    check("stall_in_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 40 && (idx < 5 || exp_q.size() != 0); c++) begin
      in_valid = (idx < 5);
      if (idx < 5) drive(p_ca[idx], p_ea[idx], p_sa[idx], p_cb[idx], p_eb[idx], p_sb[idx], p_op[idx]);
      tick();
      if (acc_in) idx++;
    end
    check("stall_all_in", idx, 5);
    check("stall_drained", exp_q.size(), 0);

    // Reset with two operands in flight, the older one parked at the output.
    in_valid = 1'b1;
    drive_rand();
    tick();
    drive_rand();
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    check("flight_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    exp_q.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("post_rst_quiet", out_valid, 0);
    end
    directed("post_rst", 4'b1000, 2'b01, 0, 4'b1000, 2'b01, 0, 0, {8'b10000000, 3'b010, 1'b0, 1'b0});

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive_rand();
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    check("random_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
